uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares the single simpleuart transmitter between NREQ byte producers, e.g. the 2SIO console port, the monitor ROM debug stream and the front-panel trace logger.
- Round-robin arbitration over valid/ready requester ports.
- Optional per-requester lock keeps a multi-byte message contiguous.
- Sequences the UART write strobe against its wait signal, so exactly one byte is loaded per grant.
- Sits between the requesters and simpleuart's reg_dat_we / reg_dat_di / reg_dat_wait pins.

Parameters:
NREQ, 4, number of requester ports (2..8).
GAP, 0, idle cycles inserted after each byte the UART accepts before the next arbitration (0..255).
LOCK_TIMEOUT, 1000000, cycles a locked-but-idle owner may hold the grant (used only with UART_ARB_TIMEOUT_EN).

Ports:
clk  in  1  system clock; single clock domain.
resetn  in  1  reset, synchronous, active-low.
req_valid  in  NREQ  requester i has a byte on req_data.
req_data  in  8*NREQ  byte of requester i is bits [8i+7:8i].
req_lock  in  NREQ  requester i asks to keep the grant after this byte.
req_ready  out  NREQ  one-hot; byte of requester i is taken when valid & ready.
uart_we  out  1  to UART reg_dat_we.
uart_di  out  8  to UART reg_dat_di.
uart_wait  in  1  from UART reg_dat_wait; high = write stalled.
grant_id  out  clog2(NREQ)  index of the last accepted requester.
lock_active  out  1  a lock is currently held.
busy  out  1  state is not IDLE.

Behaviour:
Reset values (resetn low at a clk edge):
- state=IDLE; uart_we=0; uart_di=0; grant_id=0; rr_ptr=0; lock_active=0; gap counter=0; timeout counter=0.
- req_ready=0 while resetn is low.
- Reset mid-byte drops uart_we the next cycle and abandons the byte. No retry. The requester already saw its handshake.

States:
- IDLE, ISSUE, GAP.

IDLE:
- req_ready is combinational.
- No lock: select the first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NREQ. Assert req_ready[i] for that i only.
- lock_active: only req_ready[grant_id] may assert, and only if req_valid[grant_id] is high. All other requesters are stalled.
- On handshake:
  - uart_di <= req_data[i]; grant_id <= i; lock_active <= req_lock[i].
  - rr_ptr <= (i+1) mod NREQ.
  - uart_we <= 1; go to ISSUE.
- The requester must hold req_lock stable while req_valid is high.

ISSUE:
- uart_we=1 and uart_di are held constant.
- In the cycle where uart_wait=0, the UART loads the byte. Next state:
  - uart_we <= 0;
  - go to GAP if GAP>0 (counter loaded with GAP);
  - otherwise go to IDLE.
- uart_wait=1 holds the state with no limit; this covers the UART's post-reset dummy frame.

GAP:
- Counts down to 1, then goes to IDLE.
- req_ready=0 throughout.

Lock release:
- In IDLE with lock_active, the owner's req_valid=0 and req_lock[grant_id]=0 → lock_active <= 0.
- Arbitration resumes the next cycle from rr_ptr (= owner+1).
- The owner's last byte in a message carries req_lock=0, which releases the lock at its handshake.

Throughput and latency:
- Idle UART, GAP=0: valid→uart_we is 1 cycle. One arbitration cycle plus one ISSUE cycle occurs per byte before the UART frame time.
- In practice the UART frame (10 bit times) dominates.

Simultaneous events:
- Multiple valids: the lowest index at or above rr_ptr wins, with wrap.
- A requester deasserting valid in a cycle without ready is legal; that byte is not sent.
- busy = (state != IDLE).

Optional Feature:
UART_ARB_TIMEOUT_EN
- Defined:
  - A 32-bit counter increments each IDLE cycle while lock_active is set and the owner's req_valid is low.
  - The counter clears on any owner handshake.
  - When the count reaches LOCK_TIMEOUT, lock_active is forced to 0 and normal round-robin resumes from rr_ptr.
  - Owner's later bytes re-arbitrate normally.
- Undefined:
  - No counter exists, and the LOCK_TIMEOUT parameter is ignored.
  - A lock persists until the owner releases it.

Test Plan:
1. NREQ=4, GAP=0, uart_wait tied 0; req_valid=4'b1111 held, data 0x41..0x44 → bytes 0x41,0x42,0x43,0x44,0x41 at uart_we pulses; each uart_we pulse is 1 cycle, and pulses start 2 cycles apart.
2. Requester 2 sends 0x10 (lock=1), 0x11 (lock=1), 0x12 (lock=0) while requesters 0,1,3 are valid → UART sees 0x10,0x11,0x12 contiguous, then 0x0_ from requester 3 (rr_ptr=3).
3. uart_wait=1 for 200 cycles after the handshake → uart_we and uart_di stable for 200 cycles, no req_ready asserted; wait falls → uart_we drops the next cycle.
4. GAP=5, single requester streaming → uart_we rising edges exactly 7 cycles apart with uart_wait=0.
5. resetn low for 1 cycle while in ISSUE → next cycle uart_we=0, busy=0, lock_active=0, rr_ptr=0; requester 0 wins the next contest.
6. UART_ARB_TIMEOUT_EN, LOCK_TIMEOUT=50: requester 1 locks and then idles; requester 0 valid → requester 0 is granted 50 IDLE cycles after the lock stalls, lock_active=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one simpleuart transmitter between
// NREQ valid/ready byte producers, with optional per-requester message lock.
// Optional feature macro: UART_ARB_TIMEOUT_EN (lock timeout after LOCK_TIMEOUT
// idle owner cycles). Default build: locks persist until the owner releases.
module uart_tx_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned GAP          = 0,
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    localparam int unsigned IW          = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_lock,
    output logic [NREQ-1:0]   req_ready,
    output logic              uart_we,
    output logic [7:0]        uart_di,
    input  logic              uart_wait,
    output logic [IW-1:0]     grant_id,
    output logic              lock_active,
    output logic              busy
);

    localparam int unsigned XW = IW + 1;
    localparam int unsigned GW = 8;
    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP} state_t;

    state_t            state_q, state_d;
    logic              we_d;
    logic [7:0]        di_d;
    logic [IW-1:0]     gid_d;
    logic [IW-1:0]     rr_ptr, rr_d;
    logic              lock_d;
    logic [GW-1:0]     gap_cnt, gap_d;
    logic [NREQ-1:0]   ready_c;
    logic [IW-1:0]     arb_idx;
    logic              arb_found;
    logic [XW-1:0]     idx_w;
    logic [IW-1:0]     sel;
    logic              sel_ok;
`ifdef UART_ARB_TIMEOUT_EN
    logic [CW-1:0]     to_cnt, to_d;
`endif

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        idx_w     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx_w = {1'b0, rr_ptr} + XW'(k);
            if (idx_w >= XW'(NREQ)) begin
                idx_w = idx_w - XW'(NREQ);
            end
            if (!arb_found && req_valid[idx_w[IW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = idx_w[IW-1:0];
            end
        end
    end

    // Next-state and next-output logic; req_ready is the only combinational output.
    always_comb begin
        state_d = state_q;
        we_d    = uart_we;
        di_d    = uart_di;
        gid_d   = grant_id;
        rr_d    = rr_ptr;
        lock_d  = lock_active;
        gap_d   = gap_cnt;
        ready_c = '0;
        sel     = '0;
        sel_ok  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
        to_d    = to_cnt;
`endif
        case (state_q)
            ST_IDLE: begin
                if (lock_active) begin
                    sel    = grant_id;
                    sel_ok = req_valid[grant_id];
                end else begin
                    sel    = arb_idx;
                    sel_ok = arb_found;
                end
                if (sel_ok) begin
                    ready_c[sel] = 1'b1;
                    di_d         = req_data[8*sel +: 8];
                    gid_d        = sel;
                    lock_d       = req_lock[sel];
                    rr_d         = (sel == IW'(NREQ - 1)) ? '0 : sel + IW'(1);
                    we_d         = 1'b1;
                    state_d      = ST_ISSUE;
`ifdef UART_ARB_TIMEOUT_EN
                    to_d         = '0;
`endif
                end else if (lock_active) begin
                    if (!req_lock[grant_id]) begin
                        lock_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
                        to_d   = '0;
                    end else if (to_cnt + CW'(1) >= CW'(LOCK_TIMEOUT)) begin
                        lock_d = 1'b0;
                        to_d   = '0;
                    end else begin
                        to_d   = to_cnt + CW'(1);
`endif
                    end
                end
            end
            ST_ISSUE: begin
                if (!uart_wait) begin
                    we_d = 1'b0;
                    if (GAP > 0) begin
                        gap_d   = GW'(GAP);
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt <= GW'(1)) begin
                    gap_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_cnt - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            uart_we     <= 1'b0;
            uart_di     <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            lock_active <= 1'b0;
            gap_cnt     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            uart_we     <= we_d;
            uart_di     <= di_d;
            grant_id    <= gid_d;
            rr_ptr      <= rr_d;
            lock_active <= lock_d;
            gap_cnt     <= gap_d;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt      <= to_d;
`endif
        end
    end

    assign req_ready = resetn ? ready_c : '0;
    assign busy      = (state_q != ST_IDLE);

endmodule
